// File: rtl/exec_sequencer_pkg.sv
// exec_sequencer_pkg: shared state/instruction types for the exec sequencer
package exec_sequencer_pkg;
    localparam int STATE_W = 3;
    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        STEP  = 3'd2,
        BREAK = 3'd3,
        FAULT = 3'd4
    } seq_state_t;
    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] stage;
    } instruction_t;
    function automatic logic can_launch(seq_state_t s);
        return s == IDLE || s == BREAK;
    endfunction
endpackage

// File: rtl/exec_sequencer_if.sv
// exec_sequencer_if: stage request/acknowledge handshake plus retirement pulse
interface exec_sequencer_if #(parameter int NUM_STAGES = 4);
    logic [NUM_STAGES-1:0] stage_req;
    logic [NUM_STAGES-1:0] stage_ack;
    logic                  cycle_done;
    modport master(output stage_req, cycle_done, input stage_ack);
    modport slave(input stage_req, cycle_done, output stage_ack);
endinterface

// File: rtl/exec_sequencer_stage_watchdog.sv
// stage_watchdog: counts unacknowledged cycles of the current stage
module stage_watchdog #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic stage_change,
    input  logic waiting,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt <= '0;
        else        cnt <= stage_change ? '0 : cnt + W'(waiting);
    end
    // fires on the TIMEOUT_CYCLES-th consecutive wait cycle
    assign expired = waiting && cnt == W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/exec_sequencer.sv
// exec_sequencer: run/step/break control walking each instruction through its handshake stages
module exec_sequencer
    import exec_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int NUM_STAGES     = 4,
    parameter int TIMEOUT_CYCLES = 15,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   go,
    input  logic                   step,
    input  logic                   halt_req,
    input  logic                   clear_fault,
    input  logic                   program_write,
    input  logic                   bp_enable,
    input  logic [ADDR_WIDTH-1:0]  bp_address,
    input  logic [ADDR_WIDTH-1:0]  pc,
    exec_sequencer_if.master       sif,
    output logic [2:0]             state,
    output logic                   fault,
    output logic [COUNT_WIDTH-1:0] instr_count
);
    seq_state_t st, st_n;
    logic [NUM_STAGES-1:0] req_q, req_n;
    logic done_q, halt_pend, bp_skip, start, active, ack_hit, retire, expired, bp_hit;

    assign active  = |req_q;
    assign ack_hit = |(req_q & sif.stage_ack);
    assign retire  = ack_hit && req_q[NUM_STAGES-1];
    assign bp_hit  = bp_enable && pc == bp_address && !bp_skip;

    stage_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk,
        .reset,
        .stage_change(ack_hit || !active),
        .waiting(active && !ack_hit),
        .expired
    );

    // an active instruction always completes or times out; decisions happen only at boundaries
    always_comb begin
        st_n  = st;
        req_n = req_q;
        start = 1'b0;
        if (active) begin
            req_n = expired ? '0 : ack_hit ? req_q << 1 : req_q;
            st_n  = expired ? FAULT : (retire && st == STEP) ? IDLE : st;
        end else if (can_launch(st)) begin
            st_n = step ? STEP : go ? RUN : st;
        end else if (st == FAULT) begin
            st_n = clear_fault ? IDLE : st;
        end else if (st == RUN && bp_hit) begin
            st_n = BREAK;
        end else if (st == RUN && (halt_pend || halt_req)) begin
            st_n = IDLE;
        end else begin
            start = !program_write;
            req_n = NUM_STAGES'(start);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st          <= IDLE;
            req_q       <= '0;
            done_q      <= 1'b0;
            instr_count <= '0;
            halt_pend   <= 1'b0;
            bp_skip     <= 1'b0;
        end else begin
            st          <= st_n;
            req_q       <= req_n;
            done_q      <= retire;
            instr_count <= instr_count + COUNT_WIDTH'(retire);
            halt_pend   <= st == RUN && st_n == RUN && (halt_pend || halt_req);
            // resuming from BREAK must not re-trap on the same address
            bp_skip     <= (st == BREAK && st_n != BREAK) || (bp_skip && !start);
        end
    end

    assign sif.stage_req  = req_q;
    assign sif.cycle_done = done_q;
    assign state          = st;
    assign fault          = st == FAULT;
endmodule

// File: doc/exec_sequencer.md
EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, width of program-counter and breakpoint address.
REQ-002 SHALL have parameter NUM_STAGES, default 4, number of handshake stages per instruction (min 2).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 15, max cycles a stage may wait for ack (min 1).
REQ-004 SHALL have parameter COUNT_WIDTH, default 16, width of retired-instruction counter.
REQ-005 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port reset  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port go  in  1  one-cycle pulse: start or resume free-running execution.
REQ-008 SHALL have port step  in  1  one-cycle pulse: execute exactly one instruction.
REQ-009 SHALL have port halt_req  in  1  one-cycle pulse: stop at next instruction boundary.
REQ-010 SHALL have port clear_fault  in  1  one-cycle pulse: leave FAULT.
REQ-011 SHALL have port program_write  in  1  program load in progress; blocks instruction start.
REQ-012 SHALL have port bp_enable  in  1  breakpoint compare enable.
REQ-013 SHALL have port bp_address  in  ADDR_WIDTH  breakpoint address.
REQ-014 SHALL have port pc  in  ADDR_WIDTH  address of next instruction, from program counter.
REQ-015 SHALL have port stage_ack  in  NUM_STAGES  per-stage completion acknowledge.
REQ-016 SHALL have port stage_req  out  NUM_STAGES  one-hot or zero stage request.
REQ-017 SHALL have port cycle_done  out  1  one-cycle pulse on instruction retirement.
REQ-018 SHALL have port state  out  3  encoded current state.
REQ-019 SHALL have port fault  out  1  high while in FAULT.
REQ-020 SHALL have port instr_count  out  COUNT_WIDTH  retired instructions, wraps to 0.

Function
REQ-021 SHALL implement states IDLE, RUN, STEP, BREAK, FAULT.
REQ-022 SHALL start an instruction by asserting stage_req[0] the cycle after entering RUN/STEP or after previous retirement, only if program_write is low.
REQ-023 SHALL hold stage_req[k] until the cycle stage_ack[k] is sampled high, then assert stage_req[k+1] the next cycle (1-cycle hop, no bubble beyond it).
REQ-024 SHALL ignore stage_ack bits other than the currently requested one.
REQ-025 SHALL on ack of last stage pulse cycle_done and increment instr_count (modulo 2^COUNT_WIDTH) in that same cycle.
REQ-026 SHALL in STEP return to IDLE after one retirement; in RUN continue with next instruction.
REQ-027 SHALL at each boundary in RUN evaluate, by priority: breakpoint hit (bp_enable and pc == bp_address) -> BREAK; halt_req seen since last boundary -> IDLE; else start next instruction.
REQ-028 SHALL latch halt_req mid-instruction; never abort an instruction in progress due to halt_req or program_write.
REQ-029 SHALL suppress breakpoint compare for the first instruction after leaving BREAK, so resume does not re-trap.
REQ-030 SHALL from IDLE or BREAK: step -> STEP, go -> RUN; step wins when both asserted same cycle.
REQ-031 SHALL ignore go/step while in RUN, STEP or FAULT.
REQ-032 SHALL count wait cycles per stage, reset on each stage change; if count reaches TIMEOUT_CYCLES without ack -> FAULT, stage_req cleared the next cycle.
REQ-033 SHALL leave FAULT only via clear_fault (-> IDLE) or reset; instr_count unchanged by fault.
REQ-034 SHALL stall (stage_req all zero) while program_write high at a boundary, starting on the first cycle it is low.

Reset
REQ-035 SHALL on reset low asynchronously force state IDLE, stage_req 0, cycle_done 0, fault 0, instr_count 0, halt latch and timer 0.
REQ-036 SHALL abandon any in-flight instruction on reset without pulsing cycle_done.

Structure
REQ-037 SHALL define the state enum seq_state_t in a shared package alongside instruction_t.
REQ-038 SHALL place the per-stage timeout counter in sub-module stage_watchdog (inputs: stage change, waiting; output: expired).

Verification
REQ-039 SHALL test: step pulse, acks one cycle after each req (NUM_STAGES=4) -> req walks 0..3, one cycle_done, instr_count=1, state IDLE.
REQ-040 SHALL test: go, run 3 instructions, halt_req during stage 1 of 3rd -> 3rd completes, instr_count=3, IDLE, no 4th req.
REQ-041 SHALL test: bp_address=0x05, pc reaches 0x05 in RUN -> BREAK with stage_req 0; go -> instruction at 0x05 executes without re-trap.
REQ-042 SHALL test: withhold stage_ack[2], TIMEOUT_CYCLES=15 -> FAULT after 15 wait cycles, fault=1; clear_fault -> IDLE.
REQ-043 SHALL test: instr_count preloaded path to 0xFFFF then one retirement -> 0x0000; reset mid-stage -> all outputs zero immediately.
REQ-044 SHALL test: program_write high at boundary in RUN -> no stage_req until it drops, then stage_req[0] next cycle.
